// File: rtl/wb_writer.sv
// Writeback driver: merges ALU results and load returns into one register-file write per cycle.
// Latency: ALU 1 cycle; load 1 cycle when the queue is empty and no ALU result competes, else 1 + queue wait.
// Backpressure: ALU results are never stalled; load returns stall via mem_ready when the load queue is full.
//
// Ports:
//   clk, rst                          clock and asynchronous active-high reset
//   ex_valid/ex_rd/ex_data            single-cycle ALU result (highest priority)
//   mem_valid/mem_ready/mem_rd/mem_data  load return handshake into the load queue
//   issue_load_en/issue_load_rd       decoder marks a destination as pending
//   rd_addr1/rd_addr2 -> rd_pend1/2   combinational pending-load lookups
//   wb_w_en/wb_w_addr/wb_w_data       registered register-file write port
//   lq_count                          load-queue occupancy
module wb_writer #(
  parameter int XLEN     = 32,
  parameter int LQ_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  // ALU result
  input  logic                       ex_valid,
  input  logic [4:0]                 ex_rd,
  input  logic [XLEN-1:0]            ex_data,
  // load return
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [4:0]                 mem_rd,
  input  logic [XLEN-1:0]            mem_data,
  // scoreboard interface
  input  logic                       issue_load_en,
  input  logic [4:0]                 issue_load_rd,
  input  logic [4:0]                 rd_addr1,
  input  logic [4:0]                 rd_addr2,
  output logic                       rd_pend1,
  output logic                       rd_pend2,
  // register-file write port
  output logic                       wb_w_en,
  output logic [4:0]                 wb_w_addr,
  output logic [XLEN-1:0]            wb_w_data,
  output logic [$clog2(LQ_DEPTH):0]  lq_count
);

  localparam int AW = $clog2(LQ_DEPTH);
  localparam logic [AW:0] DEPTH_C = LQ_DEPTH[AW:0];

  // ------------------------------------------------------------------
  // Load queue storage and pointers. Pointers are AW bits wide so they
  // wrap modulo LQ_DEPTH for free (depth is a power of two).
  // ------------------------------------------------------------------
  logic [4:0]      lq_rd_q   [LQ_DEPTH];
  logic [XLEN-1:0] lq_data_q [LQ_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q,  count_d;

  // Scoreboard of destinations with an outstanding load.
  logic [31:0]     pend_q, pend_d;

  // Output register.
  logic            wb_en_q,   wb_en_d;
  logic [4:0]      wb_addr_q, wb_addr_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;

  // Selection and queue control.
  logic            lq_empty;
  logic            mem_xfer;
  logic            bypass;
  logic            lq_push;
  logic            lq_pop;
  logic            sel_vld;
  logic            sel_load;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;

  // mem_ready looks only at registered occupancy so the source never sees
  // a combinational path from its own valid or from the ALU side.
  assign mem_ready = (count_q != DEPTH_C);
  assign mem_xfer  = mem_valid && mem_ready;
  assign lq_empty  = (count_q == '0);

  // A load may skip the queue only when nothing older is waiting and the
  // ALU is not using the write port; otherwise it joins the tail so that
  // loads retire strictly in arrival order.
  assign bypass  = mem_xfer && !ex_valid && lq_empty;
  assign lq_push = mem_xfer && !bypass;

  // ------------------------------------------------------------------
  // Write-source priority: ALU, then queue head, then bypassing load.
  // ------------------------------------------------------------------
  always_comb begin
    sel_vld  = 1'b0;
    sel_load = 1'b0;
    sel_rd   = '0;
    sel_data = '0;
    lq_pop   = 1'b0;
    if (ex_valid) begin
      sel_vld  = 1'b1;
      sel_rd   = ex_rd;
      sel_data = ex_data;
    end else if (!lq_empty) begin
      sel_vld  = 1'b1;
      sel_load = 1'b1;
      sel_rd   = lq_rd_q[rd_ptr_q];
      sel_data = lq_data_q[rd_ptr_q];
      lq_pop   = 1'b1;
    end else if (mem_xfer) begin
      sel_vld  = 1'b1;
      sel_load = 1'b1;
      sel_rd   = mem_rd;
      sel_data = mem_data;
    end
  end

  // ------------------------------------------------------------------
  // Queue pointer / occupancy next state.
  // ------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (lq_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (lq_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({lq_push, lq_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // ------------------------------------------------------------------
  // Scoreboard next state. The clear is applied first so that a new
  // issue to the same register on the same edge leaves it pending.
  // ------------------------------------------------------------------
  always_comb begin
    pend_d = pend_q;
    if (sel_load && (sel_rd != 5'd0)) begin
      pend_d[sel_rd] = 1'b0;
    end
    if (issue_load_en && (issue_load_rd != 5'd0)) begin
      pend_d[issue_load_rd] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  // ------------------------------------------------------------------
  // Output register next state. Writes to x0 are consumed but never
  // presented; address/data only move when a real write is issued.
  // ------------------------------------------------------------------
  always_comb begin
    wb_en_d   = sel_vld && (sel_rd != 5'd0);
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    if (wb_en_d) begin
      wb_addr_d = sel_rd;
      wb_data_d = sel_data;
    end
  end

  // ------------------------------------------------------------------
  // Sequential state.
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pend_q    <= '0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pend_q    <= pend_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  // Queue payload needs no reset: an entry is only read once the
  // occupancy (which is reset) says it has been written.
  always_ff @(posedge clk) begin
    if (lq_push) begin
      lq_rd_q[wr_ptr_q]   <= mem_rd;
      lq_data_q[wr_ptr_q] <= mem_data;
    end
  end

  // ------------------------------------------------------------------
  // Outputs.
  // ------------------------------------------------------------------
  assign rd_pend1  = pend_q[rd_addr1];
  assign rd_pend2  = pend_q[rd_addr2];
  assign wb_w_en   = wb_en_q;
  assign wb_w_addr = wb_addr_q;
  assign wb_w_data = wb_data_q;
  assign lq_count  = count_q;

endmodule

// File: tb/tb_wb_writer.sv
// Testbench for wb_writer: directed vectors with a write scoreboard.
// Latency: expected writes are queued at issue and matched by a negedge monitor.
// Backpressure: load source holds mem_valid until mem_ready is seen at the edge.
module tb_wb_writer;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic [31:0] ex_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        issue_load_en;
  logic [4:0]  issue_load_rd;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic        rd_pend1;
  logic        rd_pend2;
  logic        wb_w_en;
  logic [4:0]  wb_w_addr;
  logic [31:0] wb_w_data;
  logic [2:0]  lq_count;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks;
  int  failures;
  int  nl;

  wb_writer #(.XLEN(32), .LQ_DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_rd         (ex_rd),
    .ex_data       (ex_data),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_rd        (mem_rd),
    .mem_data      (mem_data),
    .issue_load_en (issue_load_en),
    .issue_load_rd (issue_load_rd),
    .rd_addr1      (rd_addr1),
    .rd_addr2      (rd_addr2),
    .rd_pend1      (rd_pend1),
    .rd_pend2      (rd_pend2),
    .wb_w_en       (wb_w_en),
    .wb_w_addr     (wb_w_addr),
    .wb_w_data     (wb_w_data),
    .lq_count      (lq_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic idle();
    ex_valid      = 1'b0;
    ex_rd         = '0;
    ex_data       = '0;
    mem_valid     = 1'b0;
    mem_rd        = '0;
    mem_data      = '0;
    issue_load_en = 1'b0;
    issue_load_rd = '0;
  endtask

  // Tracks T4 load retirement: once x1 is written, x2..x6 must follow
  // on consecutive cycles.
  task automatic sample_t4();
    if (nl == 1) begin
      if (wb_w_en && wb_w_addr == 5'd1) nl = 2;
    end else if (nl <= 6) begin
      chk("T4_consecutive", {wb_w_en, wb_w_addr}, {1'b1, nl[4:0]});
      nl++;
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst && wb_w_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=x%0d:%0h required=none", wb_w_addr, wb_w_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wb_write", {27'd0, wb_w_addr, wb_w_data}, {27'd0, e.rd, e.data});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    nl       = 1;
    idle();
    rd_addr1 = 5'd5;
    rd_addr2 = 5'd0;
    rst      = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_wb_en",     wb_w_en,   0);
    chk("reset_lq_count",  lq_count,  0);
    chk("reset_mem_ready", mem_ready, 1);
    chk("reset_pend",      rd_pend1,  0);
    @(posedge clk); #1;
    rst = 1'b0;

    // T1: fill three queue entries behind x0 ALU writes, mark x5 pending, reset.
    ex_valid      = 1'b1;
    ex_rd         = 5'd0;
    ex_data       = 32'h55;
    issue_load_en = 1'b1;
    issue_load_rd = 5'd5;
    for (int i = 0; i < 3; i++) begin
      mem_valid = 1'b1;
      mem_rd    = 5'(20 + i);
      mem_data  = 32'h300 + i;
      @(posedge clk); #1;
      issue_load_en = 1'b0;
    end
    idle();
    #1;
    chk("T1_lq_count_pre", lq_count, 3);
    chk("T1_pend_pre",     rd_pend1, 1);
    rst = 1'b1;
    #1;
    chk("T1_wb_en",     wb_w_en,   0);
    chk("T1_lq_count",  lq_count,  0);
    chk("T1_mem_ready", mem_ready, 1);
    chk("T1_pend",      rd_pend1,  0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // T2: single ALU write, 1-cycle latency, then idle.
    exp_q.push_back('{5'd5, 32'h0000_1234});
    ex_valid = 1'b1;
    ex_rd    = 5'd5;
    ex_data  = 32'h0000_1234;
    @(posedge clk); #1;
    idle();
    chk("T2_en_n1",   wb_w_en,   1);
    chk("T2_addr_n1", wb_w_addr, 5);
    @(posedge clk); #1;
    chk("T2_en_n2",   wb_w_en,   0);

    // T3: ALU and load collide; load waits one cycle in the queue.
    exp_q.push_back('{5'd3, 32'hA});
    exp_q.push_back('{5'd7, 32'hB});
    ex_valid  = 1'b1;
    ex_rd     = 5'd3;
    ex_data   = 32'hA;
    mem_valid = 1'b1;
    mem_rd    = 5'd7;
    mem_data  = 32'hB;
    @(posedge clk); #1;
    idle();
    chk("T3_addr_n1",  wb_w_addr, 3);
    chk("T3_count_n1", lq_count,  1);
    @(posedge clk); #1;
    chk("T3_addr_n2",  wb_w_addr, 7);
    chk("T3_count_n2", lq_count,  0);
    @(posedge clk); #1;

    // T4: ALU saturates the port for 6 cycles while loads x1..x6 stream in.
    for (int k = 0; k < 6; k++) exp_q.push_back('{5'(10 + k), 32'h100 + k});
    for (int k = 1; k <= 6; k++) exp_q.push_back('{5'(k), 32'h200 + k});
    begin
      int li;
      int acc_n;
      bit acc;
      bit full_seen;
      li        = 1;
      acc_n     = 0;
      full_seen = 1'b0;
      for (int c = 0; c < 30 && (c < 6 || li <= 6); c++) begin
        ex_valid  = (c < 6);
        ex_rd     = 5'(10 + c);
        ex_data   = 32'h100 + c;
        mem_valid = (li <= 6);
        mem_rd    = 5'(li);
        mem_data  = 32'h200 + li;
        #1;
        if (acc_n == 4 && !full_seen) begin
          chk("T4_mem_ready_full", mem_ready, 0);
          full_seen = 1'b1;
        end
        acc = mem_valid && mem_ready;
        @(posedge clk); #1;
        if (acc) begin
          li++;
          acc_n++;
        end
        sample_t4();
      end
      idle();
      for (int c = 0; c < 8; c++) begin
        @(posedge clk); #1;
        sample_t4();
      end
      chk("T4_all_loads", nl, 7);
    end

    // T5: pending bit for x9 from issue until the load is written back.
    rd_addr1      = 5'd9;
    rd_addr2      = 5'd9;
    issue_load_en = 1'b1;
    issue_load_rd = 5'd9;
    #1;
    chk("T5_pend_before", rd_pend1, 0);
    @(posedge clk); #1;
    issue_load_en = 1'b0;
    chk("T5_pend1_set", rd_pend1, 1);
    chk("T5_pend2_set", rd_pend2, 1);
    @(posedge clk); #1;
    chk("T5_pend_hold", rd_pend1, 1);
    exp_q.push_back('{5'd9, 32'h99});
    mem_valid = 1'b1;
    mem_rd    = 5'd9;
    mem_data  = 32'h99;
    @(posedge clk); #1;
    idle();
    chk("T5_wb_en",      wb_w_en,   1);
    chk("T5_wb_addr",    wb_w_addr, 9);
    chk("T5_pend_clear", rd_pend1,  0);

    // T6: x0 destinations write nothing and never mark pending.
    ex_valid      = 1'b1;
    ex_rd         = 5'd0;
    ex_data       = 32'hDEAD;
    issue_load_en = 1'b1;
    issue_load_rd = 5'd0;
    @(posedge clk); #1;
    idle();
    chk("T6_wb_en", wb_w_en, 0);
    for (int a = 0; a < 32; a++) begin
      rd_addr1 = 5'(a);
      #1;
      chk("T6_pend_zero", rd_pend1, 0);
    end
    @(posedge clk); #1;
    chk("T6_wb_en_later", wb_w_en, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
